// File: rtl/tx_block_scheduler_pkg.sv
// Shared constants and state encoding for the tx block scheduler.
package tx_block_scheduler_pkg;

    localparam int RS_K_STD = 223;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_IDLE = 3'd0;
    localparam sched_state_t ST_ARB  = 3'd1;
    localparam sched_state_t ST_PASS = 3'd2;
    localparam sched_state_t ST_PAD  = 3'd3;
    localparam sched_state_t ST_FILL = 3'd4;

    function automatic int wrap_inc(int v, int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/tx_block_scheduler_if.sv
// Byte-wide AXI-Stream bundle with N parallel lanes (one per source).
interface tx_block_scheduler_if #(
    parameter int N = 1
);
    logic [N-1:0]   valid;
    logic [N-1:0]   ready;
    logic [N-1:0]   last;
    logic [8*N-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tx_block_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
module tx_block_scheduler_rr_arbiter #(
    parameter int NUM_SRC = 4,
    localparam int IW = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tx_block_scheduler.sv
// Block-granular round-robin scheduler feeding the RS encoder byte port.
module tx_block_scheduler
    import tx_block_scheduler_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter int         RS_K      = RS_K_STD,
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter logic [7:0] FILL_BYTE = 8'h55,
    parameter bit         FILL_EN   = 1'b1,
    localparam int GW = $clog2(NUM_SRC),
    localparam int CW = $clog2(RS_K)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    tx_block_scheduler_if.slave     s_if,
    tx_block_scheduler_if.master    m_if,
    output logic [GW-1:0]           grant_id,
    output logic                    fill_active,
    output logic                    short_pulse,
    output logic                    long_pulse,
    output logic [31:0]             block_count
);

    sched_state_t  state;
    logic [CW-1:0] byte_cnt;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] arb_idx;
    logic          arb_found;
    logic          beat;
    logic          last_byte;
    logic          g_last;

    tx_block_scheduler_rr_arbiter #(
        .NUM_SRC(NUM_SRC)
    ) u_arb (
        .req  (s_if.valid),
        .ptr  (rr_ptr),
        .found(arb_found),
        .idx  (arb_idx)
    );

    assign last_byte   = (byte_cnt == CW'(RS_K - 1));
    assign g_last      = s_if.last[grant_id];
    assign beat        = m_if.valid[0] & m_if.ready[0];
    assign fill_active = (state == ST_FILL);

    // Data path is a pure mux so source bytes reach tx_chain with no latency.
    always_comb begin
        m_if.valid = '0;
        m_if.data  = '0;
        m_if.last  = '0;
        s_if.ready = '0;
        unique case (state)
            ST_PASS: begin
                m_if.valid[0]        = s_if.valid[grant_id];
                m_if.data            = s_if.data[8*grant_id +: 8];
                m_if.last[0]         = last_byte;
                s_if.ready[grant_id] = m_if.ready[0];
            end
            ST_PAD: begin
                m_if.valid[0] = 1'b1;
                m_if.data     = PAD_BYTE;
                m_if.last[0]  = last_byte;
            end
            ST_FILL: begin
                m_if.valid[0] = 1'b1;
                m_if.data     = FILL_BYTE;
                m_if.last[0]  = last_byte;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            block_count <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (enable) state <= ST_ARB;
                end
                ST_ARB: begin
                    if (arb_found) begin
                        state    <= ST_PASS;
                        grant_id <= arb_idx;
                        rr_ptr   <= GW'(wrap_inc(int'(arb_idx), NUM_SRC));
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end else if (FILL_EN) begin
                        state <= ST_FILL;
                    end
                end
                ST_PASS: begin
                    if (beat) begin
                        if (last_byte) begin
                            long_pulse <= !g_last;
                        end else if (g_last) begin
                            state       <= ST_PAD;
                            short_pulse <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Block close overrides any per-state transition above.
            if (beat) begin
                if (last_byte) begin
                    byte_cnt    <= '0;
                    block_count <= block_count + 1;
                    grant_id    <= '0;
                    state       <= enable ? ST_ARB : ST_IDLE;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule
